// File: rtl/pipeline_hazard_tracker.sv
// Pipeline hazard tracker: follows the destination registers of the instructions
// in EXE/MEM/WB, detects load-use hazards against the instruction in ID, and
// generates stall/flush controls plus saturating event counters.
//
// state | meaning
// ------+-------------------------------------------------------------------
// RUN   | normal flow; PC and IF/ID advance, ID instruction enters EXE
// STALL | load-use hold; PC and IF/ID frozen, bubble into EXE
// FLUSH | taken control transfer; IF/ID cleared, bubble into EXE, PC moves
//
// state_cur is the state the machine is in for the current cycle. It is formed
// combinationally from the previous cycle's state (state_q) and the live hazard
// inputs, so a stall or flush acts in the same cycle its cause is seen. A STALL
// or FLUSH lasts exactly one cycle.

module pipeline_hazard_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             id_valid,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic [4:0]       id_waddr,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_exe_bubble,
  output logic             if_id_flush,
  output logic             exe_mem_reg_write,
  output logic             mem_wb_reg_write,
  output logic [4:0]       exe_mem_waddr,
  output logic [4:0]       mem_wb_waddr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // The EXE tag carries mem_read because load-use detection needs it there.
  // Once the producer has left EXE its load result is available for forwarding,
  // so MEM and WB only keep what the forwarding logic consumes.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic [4:0] waddr;
  } exe_tag_t;

  typedef struct packed {
    logic       reg_write;
    logic [4:0] waddr;
  } fwd_tag_t;

  state_t   state_q;
  state_t   state_cur;
  exe_tag_t exe_tag;
  exe_tag_t id_tag;
  fwd_tag_t mem_tag;
  fwd_tag_t wb_tag;
  logic     load_use;

  // Tag presented by the ID stage; writes to r0 are never tracked.
  always_comb begin
    id_tag.reg_write = id_reg_write && (id_waddr != 5'd0);
    id_tag.mem_read  = id_mem_read;
    id_tag.waddr     = id_waddr;
  end

  // Load in EXE whose destination is read by the instruction in ID.
  always_comb begin
    load_use = 1'b0;
    if (id_valid && exe_tag.mem_read && exe_tag.reg_write && (exe_tag.waddr != 5'd0)) begin
      load_use = (exe_tag.waddr == id_rs) ||
                 (id_uses_rt && (exe_tag.waddr == id_rt));
    end
  end

  // Current-cycle state; a taken branch outranks a load-use stall.
  always_comb begin
    state_cur = RUN;
    if (!arst) begin
      unique case (state_q)
        RUN: begin
          if (branch_taken) begin
            state_cur = FLUSH;
          end else if (load_use) begin
            state_cur = STALL;
          end
        end
        STALL: begin
          if (branch_taken) begin
            state_cur = FLUSH;
          end
        end
        FLUSH: begin
          state_cur = RUN;
        end
        default: begin
          state_cur = RUN;
        end
      endcase
    end
  end

  // Pipeline control enables decoded from the current-cycle state.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_exe_bubble = 1'b0;
    if_id_flush   = 1'b0;
    unique case (state_cur)
      STALL: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_exe_bubble = 1'b1;
      end
      FLUSH: begin
        if_id_flush   = 1'b1;
        id_exe_bubble = 1'b1;
      end
      default: begin
        pc_write      = 1'b1;
      end
    endcase
  end

  // Remember this cycle's state so the next cycle knows a stall/flush just ran.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_cur;
    end
  end

  // Shadow tags advance one stage per clock; a bubble or empty ID slot enters as zero.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      exe_tag <= '0;
      mem_tag <= '0;
      wb_tag  <= '0;
    end else begin
      if (id_valid && !id_exe_bubble) begin
        exe_tag <= id_tag;
      end else begin
        exe_tag <= '0;
      end
      mem_tag.reg_write <= exe_tag.reg_write;
      mem_tag.waddr     <= exe_tag.waddr;
      wb_tag            <= mem_tag;
    end
  end

  assign exe_mem_reg_write = mem_tag.reg_write;
  assign exe_mem_waddr     = mem_tag.waddr;
  assign mem_wb_reg_write  = wb_tag.reg_write;
  assign mem_wb_waddr      = wb_tag.waddr;

  // Saturating counts of frozen-PC cycles and IF/ID flush cycles.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (if_id_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_tracker.sv
// Directed bench for pipeline_hazard_tracker with a cycle-level reference model
// built on a history queue of issued instruction tags.

module tb_pipeline_hazard_tracker;

  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  localparam int A_RUN   = 0;
  localparam int A_STALL = 1;
  localparam int A_FLUSH = 2;

  logic             clk;
  logic             arst;
  logic             id_valid;
  logic             id_reg_write;
  logic             id_mem_read;
  logic [4:0]       id_waddr;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             branch_taken;
  logic             pc_write;
  logic             if_id_write;
  logic             id_exe_bubble;
  logic             if_id_flush;
  logic             exe_mem_reg_write;
  logic             mem_wb_reg_write;
  logic [4:0]       exe_mem_waddr;
  logic [4:0]       mem_wb_waddr;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  pipeline_hazard_tracker #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .arst              (arst),
    .id_valid          (id_valid),
    .id_reg_write      (id_reg_write),
    .id_mem_read       (id_mem_read),
    .id_waddr          (id_waddr),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .id_uses_rt        (id_uses_rt),
    .branch_taken      (branch_taken),
    .pc_write          (pc_write),
    .if_id_write       (if_id_write),
    .id_exe_bubble     (id_exe_bubble),
    .if_id_flush       (if_id_flush),
    .exe_mem_reg_write (exe_mem_reg_write),
    .mem_wb_reg_write  (mem_wb_reg_write),
    .exe_mem_waddr     (exe_mem_waddr),
    .mem_wb_waddr      (mem_wb_waddr),
    .stall_cnt         (stall_cnt),
    .flush_cnt         (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: q[k] is the tag that entered EXE k+1 cycles ago.
  typedef struct packed {
    bit       rw;
    bit       mr;
    bit [4:0] wa;
  } mtag_t;

  mtag_t q[$];
  int    m_stall;
  int    m_flush;
  int    m_prev;

  always @(negedge clk) begin
    mtag_t exe;
    mtag_t nt;
    bit    lu;
    int    act;
    if (arst) begin
      q.delete();
      for (int i = 0; i < 3; i++) q.push_back(mtag_t'(0));
      m_stall = 0;
      m_flush = 0;
      m_prev  = A_RUN;
      chk("rst_pc_write", int'(pc_write), 1);
      chk("rst_if_id_write", int'(if_id_write), 1);
      chk("rst_bubble", int'(id_exe_bubble), 0);
      chk("rst_flush", int'(if_id_flush), 0);
      chk("rst_exe_mem", int'({exe_mem_reg_write, exe_mem_waddr}), 0);
      chk("rst_mem_wb", int'({mem_wb_reg_write, mem_wb_waddr}), 0);
      chk("rst_cnts", int'({stall_cnt, flush_cnt}), 0);
    end else begin
      exe = q[0];
      lu  = id_valid && exe.mr && exe.rw && (exe.wa != 0) &&
            ((exe.wa == id_rs) || (id_uses_rt && (exe.wa == id_rt)));
      if (m_prev == A_FLUSH)            act = A_RUN;
      else if (branch_taken)            act = A_FLUSH;
      else if (m_prev == A_RUN && lu)   act = A_STALL;
      else                              act = A_RUN;

      chk("pc_write", int'(pc_write), (act == A_STALL) ? 0 : 1);
      chk("if_id_write", int'(if_id_write), (act == A_STALL) ? 0 : 1);
      chk("id_exe_bubble", int'(id_exe_bubble), (act == A_RUN) ? 0 : 1);
      chk("if_id_flush", int'(if_id_flush), (act == A_FLUSH) ? 1 : 0);
      chk("exe_mem_reg_write", int'(exe_mem_reg_write), int'(q[1].rw));
      chk("exe_mem_waddr", int'(exe_mem_waddr), int'(q[1].wa));
      chk("mem_wb_reg_write", int'(mem_wb_reg_write), int'(q[2].rw));
      chk("mem_wb_waddr", int'(mem_wb_waddr), int'(q[2].wa));
      chk("stall_cnt", int'(stall_cnt), m_stall);
      chk("flush_cnt", int'(flush_cnt), m_flush);

      nt = '0;
      if (id_valid && act == A_RUN) begin
        nt.rw = id_reg_write && (id_waddr != 0);
        nt.mr = id_mem_read;
        nt.wa = id_waddr;
      end
      q.push_front(nt);
      void'(q.pop_back());
      if (act == A_STALL && m_stall < SAT) m_stall++;
      if (act == A_FLUSH && m_flush < SAT) m_flush++;
      m_prev = act;
    end
  end

  task automatic drive(input bit v, input bit rw, input bit mr, input int wa,
                       input int rs, input int rt, input bit urt, input bit br);
    @(posedge clk);
    #1;
    id_valid     = v;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_waddr     = 5'(wa);
    id_rs        = 5'(rs);
    id_rt        = 5'(rt);
    id_uses_rt   = urt;
    branch_taken = br;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input int wa);
    drive(1, 1, 1, wa, 1, 2, 1, 0);
  endtask

  task automatic cons(input int rs, input bit br);
    drive(1, 1, 0, 9, rs, 10, 1, br);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst = 1'b1;
    id_valid = 0; id_reg_write = 0; id_mem_read = 0;
    id_waddr = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    branch_taken = 1'b1;
    @(negedge clk);
    chk("lit_rst_branch_flush", int'(if_id_flush), 0);
    chk("lit_rst_branch_pc", int'(pc_write), 1);
    idle();
    @(negedge clk);
    @(posedge clk);
    #1 arst = 1'b0;

    // ALU write to r5, then an independent instruction.
    drive(1, 1, 0, 5, 1, 2, 1, 0);
    drive(1, 1, 0, 6, 7, 8, 1, 0);
    idle();
    @(negedge clk);
    chk("lit_alu_exe_mem_waddr", int'(exe_mem_waddr), 5);
    chk("lit_alu_exe_mem_rw", int'(exe_mem_reg_write), 1);
    idle();
    @(negedge clk);
    chk("lit_alu_mem_wb_waddr", int'(mem_wb_waddr), 5);
    chk("lit_alu_stall_cnt", int'(stall_cnt), 0);

    // Load r3 then a consumer of r3: one stall cycle, consumer captured after.
    load(3);
    cons(3, 0);
    @(negedge clk);
    chk("lit_lu_pc_write", int'(pc_write), 0);
    chk("lit_lu_bubble", int'(id_exe_bubble), 1);
    cons(3, 0);
    @(negedge clk);
    chk("lit_lu_release", int'(pc_write), 1);
    chk("lit_lu_stall_cnt", int'(stall_cnt), 1);
    idle();
    idle();
    @(negedge clk);
    chk("lit_lu_consumer_mem", int'(exe_mem_waddr), 9);

    // Back-to-back loads, each consumer stalls once.
    load(3);
    drive(1, 1, 1, 4, 3, 0, 0, 0);
    drive(1, 1, 1, 4, 3, 0, 0, 0);
    cons(4, 0);
    cons(4, 0);
    // rt dependency only counts when rt is actually read.
    load(7);
    drive(1, 1, 0, 9, 1, 7, 0, 0);
    idle();
    load(7);
    drive(1, 1, 0, 9, 1, 7, 1, 0);
    drive(1, 1, 0, 9, 1, 7, 1, 0);
    idle();
    @(negedge clk);
    chk("lit_b2b_stall_cnt", int'(stall_cnt), 4);

    // Load to r0: never a hazard, never a tracked write.
    load(0);
    cons(0, 0);
    @(negedge clk);
    chk("lit_r0_no_stall", int'(pc_write), 1);
    idle();
    @(negedge clk);
    chk("lit_r0_rw", int'(exe_mem_reg_write), 0);

    // Branch together with load-use: flush wins.
    load(3);
    cons(3, 1);
    @(negedge clk);
    chk("lit_br_flush", int'(if_id_flush), 1);
    chk("lit_br_pc_write", int'(pc_write), 1);
    idle();
    @(negedge clk);
    chk("lit_br_flush_once", int'(if_id_flush), 0);
    chk("lit_br_flush_cnt", int'(flush_cnt), 1);
    chk("lit_br_stall_cnt", int'(stall_cnt), 4);

    // Branch resolving during a stall cycle's successor.
    load(3);
    cons(3, 0);
    cons(3, 1);
    @(negedge clk);
    chk("lit_stall_then_flush", int'(if_id_flush), 1);
    idle();

    // Drive the stall counter into saturation.
    for (int i = 0; i < 12; i++) begin
      load(3);
      cons(3, 0);
      cons(3, 0);
    end
    idle();
    @(negedge clk);
    chk("lit_sat_reached", int'(stall_cnt), 15);
    load(3);
    cons(3, 0);
    @(negedge clk);
    chk("lit_sat_stalling", int'(pc_write), 0);
    cons(3, 0);
    @(negedge clk);
    chk("lit_sat_hold", int'(stall_cnt), 15);

    // Reset pulse in the middle of a stall.
    load(5);
    cons(5, 0);
    @(negedge clk);
    chk("lit_pre_rst_stall", int'(pc_write), 0);
    #1 arst = 1'b1;
    #1;
    chk("lit_rst_pc_write", int'(pc_write), 1);
    chk("lit_rst_bubble", int'(id_exe_bubble), 0);
    chk("lit_rst_exe_mem", int'(exe_mem_waddr), 0);
    chk("lit_rst_mem_wb", int'(mem_wb_waddr), 0);
    chk("lit_rst_stall_cnt", int'(stall_cnt), 0);
    idle();
    @(posedge clk);
    #1 arst = 1'b0;

    load(3);
    cons(3, 0);
    cons(3, 0);
    @(negedge clk);
    chk("lit_post_rst_stall_cnt", int'(stall_cnt), 1);
    idle();
    idle();
    @(negedge clk);
    chk("lit_post_rst_consumer", int'(exe_mem_waddr), 9);
    idle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
